reg_share_arbiter: RTL

- Round-robin arbiter that shares a single WIDTH-bit D flip-flop register between NREQ requesters.
- Each requester raises req with its write data. The arbiter grants one requester at a time, loads that requester's data into the shared register, and pulses done.
- Sits in front of the flip-flop storage so multiple producers can update one state register without contention.

---
 rtl/reg_share_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_share_arbiter
// Brief    : Round-robin arbiter sharing one WIDTH-bit register among NREQ
//            requesters. Optional owner lock enabled by macro ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
module reg_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  wdata,
`ifdef ARB_LOCK_EN
    input  logic                   lock,
`endif
    output logic [NREQ-1:0]        gnt,
    output logic [WIDTH-1:0]       q,
    output logic [IDXW-1:0]        owner,
    output logic                   done,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [WIDTH-1:0]  r_q;
    logic [IDXW-1:0]   r_owner;
    logic [IDXW-1:0]   r_ptr;
    logic              r_done;
    logic              r_busy;

    logic [IDXW-1:0]   w_win;
    logic [IDXW-1:0]   w_next_ptr;
    int                w_scan;

`ifdef ARB_LOCK_EN
    localparam logic [2:0] c_LOCK_MAX = 3'd4;
    logic [2:0]        r_lock_cnt;
`endif

    function automatic logic [NREQ-1:0] f_onehot(input logic [IDXW-1:0] idx);
        f_onehot      = '0;
        f_onehot[idx] = 1'b1;
    endfunction

    // Scan downward so the requester closest to ptr is the last one assigned.
    always_comb begin
        w_win  = '0;
        w_scan = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= NREQ) begin
                w_scan = w_scan - NREQ;
            end
            if (req[w_scan[IDXW-1:0]]) begin
                w_win = w_scan[IDXW-1:0];
            end
        end
    end

    assign w_next_ptr = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_q        <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef ARB_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt      <= f_onehot(w_win);
                        r_owner    <= w_win;
                        r_state    <= ST_GRANT;
                        r_busy     <= 1'b1;
`ifdef ARB_LOCK_EN
                        r_lock_cnt <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    r_gnt <= '0;
                    if (req[r_owner]) begin
                        r_q        <= wdata[int'(r_owner)*WIDTH +: WIDTH];
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
`ifdef ARB_LOCK_EN
                        r_lock_cnt <= r_lock_cnt + 1'b1;
`endif
                    end else begin
                        // Abandoned grant: move on without touching q.
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
`ifdef ARB_LOCK_EN
                    if (lock && req[r_owner] && (r_lock_cnt < c_LOCK_MAX)) begin
                        r_gnt   <= f_onehot(r_owner);
                        r_state <= ST_GRANT;
                    end else begin
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
`else
                    r_ptr   <= w_next_ptr;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign q     = r_q;
    assign owner = r_owner;
    assign done  = r_done;
    assign busy  = r_busy;

endmodule
`default_nettype wire
